// File: rtl/dataflow_merge.sv
// dataflow_merge: two-source round-robin merge onto one valid/ready stream.
// The output side is a one-deep output register plus a one-deep skid register.
// i_ready is derived only from registered state and the source valids, never from o_ready.

module dataflow_merge #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         i_valid,
    output logic [1:0]         i_ready,
    input  logic [2*WIDTH-1:0] i_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_select
);

    // Round-robin pointer naming the preferred source when both are valid.
    logic             rr;

    // Second storage slot, filled only when the output register is stalled.
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_select;

    logic [1:0]       grant;
    logic             in_xfer;
    logic             out_xfer;
    logic             in_select;
    logic [WIDTH-1:0] in_data;

    // Arbitration and handshake decode; ready is held low in reset and when both slots are full.
    always_comb begin
        grant     = 2'b00;
        grant[0]  = i_valid[0] && (!i_valid[1] || !rr);
        grant[1]  = i_valid[1] && (!i_valid[0] || rr);
        i_ready   = (reset_n && !skid_valid) ? grant : 2'b00;
        in_xfer   = |(i_valid & i_ready);
        in_select = i_ready[1];
        in_data   = in_select ? i_data[2*WIDTH-1:WIDTH] : i_data[WIDTH-1:0];
        out_xfer  = o_valid && o_ready;
    end

    // After each accepted word the other source becomes the preferred one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr <= 1'b0;
        end else if (in_xfer) begin
            rr <= ~in_select;
        end
    end

    // Output and skid registers: refill from skid first, otherwise take the new word
    // into whichever slot is free; a word only enters skid while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_select    <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_select <= 1'b0;
        end else begin
            if (out_xfer && skid_valid) begin
                o_data     <= skid_data;
                o_select   <= skid_select;
                skid_valid <= 1'b0;
            end else if (in_xfer && (!o_valid || out_xfer)) begin
                o_valid  <= 1'b1;
                o_data   <= in_data;
                o_select <= in_select;
            end else if (in_xfer) begin
                skid_valid  <= 1'b1;
                skid_data   <= in_data;
                skid_select <= in_select;
            end else if (out_xfer) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dataflow_merge.md
DATAFLOW_MERGE -- requirements
Module: dataflow_merge

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the payload width in bits of each stream.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_valid  input  2  per-source valid; bit n belongs to source n.
REQ-005 SHALL have port i_ready  output  2  per-source ready; bit n belongs to source n.
REQ-006 SHALL have port i_data  input  2*WIDTH  source 0 payload in [WIDTH-1:0], source 1 in [2*WIDTH-1:WIDTH].
REQ-007 SHALL have port o_valid  output  1  merged stream valid.
REQ-008 SHALL have port o_ready  input  1  merged stream ready from the sink.
REQ-009 SHALL have port o_data  output  WIDTH  merged payload.
REQ-010 SHALL have port o_select  output  1  index of the source that supplied the current o_data.

Function
REQ-011 SHALL count a transfer on source n in any cycle with i_valid[n] && i_ready[n], and on the output in any cycle with o_valid && o_ready.
REQ-012 SHALL hold a round-robin pointer rr (1 bit) naming the preferred source.
REQ-013 SHALL grant source n when i_valid[n] is high and either the other source is not valid or rr == n; at most one grant per cycle.
REQ-014 SHALL drive i_ready[n] = grant[n] && !skid_valid, where skid_valid is a registered flag; i_ready SHALL never depend on o_ready combinationally.
REQ-015 SHALL set rr to the source not accepted, on the edge after each accepted input transfer; rr SHALL be unchanged in cycles without an input transfer.
REQ-016 SHALL hold an output register (o_valid, o_data, o_select) and one skid register (skid_valid, skid_data, skid_select).
REQ-017 SHALL load an accepted input into the output register when o_valid is low or an output transfer occurs the same cycle; otherwise into the skid register.
REQ-018 SHALL, on an output transfer with skid_valid high, move skid contents to the output register and clear skid_valid; no input is accepted that cycle per REQ-014.
REQ-019 SHALL, on an output transfer with skid_valid low and no input transfer, clear o_valid.
REQ-020 SHALL hold o_data and o_select stable while o_valid && !o_ready.
REQ-021 SHALL give a latency of exactly one cycle from input transfer to o_valid when the output register is empty or draining.
REQ-022 SHALL sustain one transfer per cycle when o_ready stays high.
REQ-023 SHALL preserve per-source order and lose or duplicate no word under any o_ready pattern.
REQ-024 SHALL drop i_ready to 0 for both sources whenever skid_valid is high (both registers full).
REQ-025 SHALL accept no transfer when neither source is valid.

Reset
REQ-026 SHALL, while reset_n is low, force o_valid=0, o_data=0, o_select=0, skid_valid=0, skid_data=0, skid_select=0, rr=0, and i_ready=2'b00.
REQ-027 SHALL discard any held or in-flight word when reset_n is asserted mid-operation; first grant after release goes to source 0 if both are valid.

Verification
REQ-028 Both sources valid continuously, o_ready=1, WIDTH=16, src0 data 0x0A00+k, src1 0x0B00+k -> outputs alternate src0,src1,src0,..., o_select 0,1,0,..., one word per cycle after 1-cycle latency.
REQ-029 Only source 1 valid with 0x1234, o_ready=1 -> i_ready=2'b10, next cycle o_valid=1, o_data=0x1234, o_select=1.
REQ-030 Both valid, o_ready held 0 -> two words accepted (output + skid), then i_ready=2'b00; on raising o_ready, both emerge in acceptance order on consecutive cycles with no loss.
REQ-031 Random o_ready at 50% with both sources streaming 200 words each -> scoreboard sees all 400 words, per-source order intact, o_data stable while stalled.
REQ-032 Assert reset_n low with output and skid full -> o_valid=0 and i_ready=2'b00 immediately; after release with both valid, first grant to source 0.
